// File: rtl/cpld_uart_pkg.sv
// Shared UART definitions: state encodings, frame geometry, default baud divisor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpld_uart_pkg;

    localparam int FRAME_BITS       = 10;   // start + 8 data + stop
    localparam int DATA_BITS        = 8;
    localparam int BAUD_DIV_DEFAULT = 217;  // 25 MHz / 115200

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/cpld_uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer (bypassed under CPLD_UART_LOOPBACK_EN), RX FSM, bit timer.
// Latency: byte_valid pulses ~9.5 bit times + 3 clocks after the start edge.
// Backpressure: none; a completed byte is presented once and must be taken that cycle.
module cpld_uart_rx_core
    import cpld_uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 byte_valid
);

    localparam int             CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_bit;
    rx_state_t            state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [2:0]           bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 frm_err, frm_err_nxt;
    logic                 valid_nxt;

`ifdef CPLD_UART_LOOPBACK_EN
    // Internal loopback source is already in this clock domain.
    assign rx_bit = rx_in;
`else
    logic sync1, sync2;

    // Two-stage synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    assign rx_bit = sync2;
`endif

    assign rx_byte = shreg;

    // RX state, timer and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            frm_err    <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            frm_err    <= frm_err_nxt;
            byte_valid <= valid_nxt;
        end
    end

    // RX next-state: mid-bit sampling driven by a down-counting bit timer.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        frm_err_nxt = frm_err;
        valid_nxt   = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_bit) begin
                    state_nxt = RX_START;
                    cnt_nxt   = HALF_LAST;
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (rx_bit) begin
                        state_nxt = RX_IDLE;        // glitch, not a start bit
                    end else begin
                        state_nxt   = RX_DATA;
                        cnt_nxt     = CNT_LAST;
                        bit_idx_nxt = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shreg_nxt[bit_idx] = rx_bit;
                    cnt_nxt            = CNT_LAST;
                    if (bit_idx == BIT_LAST) begin
                        state_nxt = RX_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (frm_err) begin
                    // Hold off until the line goes idle so a low stop bit
                    // is not mistaken for the next start bit.
                    if (rx_bit) begin
                        frm_err_nxt = 1'b0;
                        state_nxt   = RX_IDLE;
                    end
                end else if (cnt == '0) begin
                    if (rx_bit) begin
                        valid_nxt = 1'b1;
                        state_nxt = RX_IDLE;
                    end else begin
                        frm_err_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/cpld_uart.sv
// CPLD-style UART responder: byte bus (wrn/rdn) to 8N1 serial; loopback under CPLD_UART_LOOPBACK_EN.
// Latency: write commit to txd start bit 1 clock when idle; frame 10*BAUD_DIV clocks.
// Backpressure: tbre=0 means THR full and further writes are dropped; dataReady flags RBR.
module cpld_uart
    import cpld_uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdn,
    input  logic                 wrn,
    inout  wire  [DATA_BITS-1:0] ram1DataBus,
    output logic                 tbre,
    output logic                 tsre,
    output logic                 dataReady,
    input  logic                 rxd,
    output logic                 txd
);

    localparam int             CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [3:0]     POS_LAST = 4'(FRAME_BITS - 2);  // last data position

    logic                 wrn_q, rdn_q;
    logic                 commit, rd_rise;
    logic [DATA_BITS-1:0] cap, thr, tsr, rbr, pend_dat;
    logic                 pend;

    tx_state_t            tx_state, tx_state_nxt;
    logic [CW-1:0]        tx_cnt, tx_cnt_nxt;
    logic [3:0]           tx_pos, tx_pos_nxt;
    logic                 txd_nxt, tsre_nxt, tx_load;

    logic                 rx_src;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 byte_valid;

    // Writes land on wrn rising; a full THR or a concurrent read strobe drops them.
    assign commit  = ~wrn_q & wrn & tbre & rdn;
    assign rd_rise = ~rdn_q & rdn;

    assign ram1DataBus = rdn ? {DATA_BITS{1'bz}} : rbr;

    // Strobe history and write-data capture while wrn is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrn_q <= 1'b1;
            rdn_q <= 1'b1;
            cap   <= '0;
        end else begin
            wrn_q <= wrn;
            rdn_q <= rdn;
            if (!wrn) cap <= ram1DataBus;
        end
    end

    // Transmit holding register and its empty flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thr  <= '0;
            tbre <= 1'b1;
        end else if (commit) begin
            thr  <= cap;
            tbre <= 1'b0;
        end else if (tx_load) begin
            tbre <= 1'b1;
        end
    end

    // TX state, bit timer, shift register and line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_pos   <= '0;
            tsr      <= '0;
            txd      <= 1'b1;
            tsre     <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_pos   <= tx_pos_nxt;
            txd      <= txd_nxt;
            tsre     <= tsre_nxt;
            if (tx_load) tsr <= thr;
        end
    end

    // TX next-state: tx_pos is the frame position (0 = start, 1..8 = data).
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_pos_nxt   = tx_pos;
        txd_nxt      = txd;
        tsre_nxt     = tsre;
        tx_load      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tbre) begin
                    tx_load      = 1'b1;
                    tx_state_nxt = TX_START;
                    tx_cnt_nxt   = CNT_LAST;
                    tx_pos_nxt   = '0;
                    txd_nxt      = 1'b0;
                    tsre_nxt     = 1'b0;
                end
            end
            TX_START, TX_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_nxt = CNT_LAST;
                    tx_pos_nxt = tx_pos + 4'd1;
                    if (tx_pos == POS_LAST) begin
                        tx_state_nxt = TX_STOP;
                        txd_nxt      = 1'b1;
                    end else begin
                        tx_state_nxt = TX_DATA;
                        txd_nxt      = tsr[tx_pos[2:0]];
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - CNT_ONE;
                end
            end
            TX_STOP: begin
                // Returning through IDLE gives the one-cycle tsre pulse
                // before a queued frame starts.
                if (tx_cnt == '0) begin
                    tx_state_nxt = TX_IDLE;
                    tsre_nxt     = 1'b1;
                end else begin
                    tx_cnt_nxt = tx_cnt - CNT_ONE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

`ifdef CPLD_UART_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = rxd;
    assign rx_src     = txd;
`else
    assign rx_src = rxd;
`endif

    cpld_uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_src),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid)
    );

    // RBR update, deferred while a read strobe is active so bus data stays stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbr      <= '0;
            pend_dat <= '0;
            pend     <= 1'b0;
        end else if (byte_valid) begin
            if (!rdn) begin
                pend_dat <= rx_byte;
                pend     <= 1'b1;
            end else begin
                rbr  <= rx_byte;
                pend <= 1'b0;
            end
        end else if (pend && rdn) begin
            rbr  <= pend_dat;
            pend <= 1'b0;
        end
    end

    // dataReady: a completing byte takes priority over the read-strobe clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataReady <= 1'b0;
        end else if (byte_valid) begin
            dataReady <= 1'b1;
        end else if (rd_rise) begin
            dataReady <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpld_uart.sv
// Testbench for cpld_uart: randomized bytes against an 8N1 frame model.
// Latency: checks are taken on falling clock edges.
// Backpressure: exercises dropped writes and overrun behaviour.
module tb_cpld_uart;

    localparam int B = 8;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       rdn    = 1'b1;
    logic       wrn    = 1'b1;
    logic       rxd    = 1'b1;
    logic [7:0] drv    = 8'h00;
    logic       drv_en = 1'b0;
    wire  [7:0] bus;
    wire        tbre, tsre, dataReady, txd;

    int checks = 0;
    int errors = 0;

    assign bus = drv_en ? drv : 8'hzz;

    always #5 clk = ~clk;

    cpld_uart #(.BAUD_DIV(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdn         (rdn),
        .wrn         (wrn),
        .ram1DataBus (bus),
        .tbre        (tbre),
        .tsre        (tsre),
        .dataReady   (dataReady),
        .rxd         (rxd),
        .txd         (txd)
    );

    // 8N1 line level at frame position k: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        return 1'b1;
    endfunction

    task automatic cpu_write(input logic [7:0] d);
        @(negedge clk);
        drv = d; drv_en = 1'b1; wrn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wrn = 1'b1; drv_en = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        for (int k = 0; k < 10; k++) begin
            rxd = (k == 9) ? stop : frame_bit(d, k);
            repeat (B) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({txd, tbre, tsre, dataReady} !== 4'b1110) begin
            errors++; $display("FAIL reset_state got %b want 1110", {txd, tbre, tsre, dataReady});
        end
        rst = 1'b1;
        drv = 8'h96; drv_en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus !== 8'h96) begin
            errors++; $display("FAIL bus_released got %h want 96", bus);
        end
        drv_en = 1'b0;
        // Reset in the middle of a frame.
        cpu_write(8'h00);
        repeat (B + 4) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin
            errors++; $display("FAIL midframe_txd got %b want 0", txd);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({txd, tbre, tsre, dataReady} !== 4'b1110) begin
            errors++; $display("FAIL async_reset got %b want 1110", {txd, tbre, tsre, dataReady});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2 * B) @(negedge clk);
        checks++;
        if ({txd, tbre, tsre} !== 3'b111) begin
            errors++; $display("FAIL after_reset_idle got %b want 111", {txd, tbre, tsre});
        end
    endtask

    task automatic test_write();
        logic [7:0] d;
        for (int n = 0; n < 4; n++) begin
            d = (n == 0) ? 8'hA5 : 8'($urandom);
            cpu_write(d);
            @(negedge clk);
            checks++;
            if ({tbre, txd} !== 2'b01) begin
                errors++; $display("FAIL tbre_low d=%h got %b want 01", d, {tbre, txd});
            end
            @(negedge clk);
            checks++;
            if ({tbre, txd, tsre} !== 3'b100) begin
                errors++; $display("FAIL start_bit d=%h got %b want 100", d, {tbre, txd, tsre});
            end
            for (int j = 1; j < 10 * B; j++) begin
                @(negedge clk);
                checks++;
                if (txd !== frame_bit(d, j / B)) begin
                    errors++; $display("FAIL tx_bit d=%h j=%0d got %b want %b", d, j, txd, frame_bit(d, j / B));
                end
                if (j == 10 * B - 1) begin
                    checks++;
                    if (tsre !== 1'b0) begin
                        errors++; $display("FAIL tsre_early d=%h got %b want 0", d, tsre);
                    end
                end
            end
            @(negedge clk);
            checks++;
            if ({tsre, txd} !== 2'b11) begin
                errors++; $display("FAIL tsre_rise d=%h got %b want 11", d, {tsre, txd});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        logic       exp;
        a = 8'h12; b = 8'h34;
        cpu_write(a);
        repeat (2) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin
            errors++; $display("FAIL b2b_start got %b want 0", txd);
        end
        for (int j = 1; j < 23 * B; j++) begin
            @(negedge clk);
            if (j < 10 * B)           exp = frame_bit(a, j / B);
            else if (j == 10 * B)     exp = 1'b1;
            else if (j < 20 * B + 1)  exp = frame_bit(b, (j - 10 * B - 1) / B);
            else                      exp = 1'b1;
            checks++;
            if (txd !== exp) begin
                errors++; $display("FAIL b2b_txd j=%0d got %b want %b", j, txd, exp);
            end
            if (j == 8 || j == 10 * B) begin
                checks++;
                if (tbre !== 1'b0) begin
                    errors++; $display("FAIL b2b_tbre_full j=%0d got %b want 0", j, tbre);
                end
            end
            if (j == 10 * B || j == 10 * B + 1 || j == 23 * B - 1) begin
                checks++;
                if (tsre !== (j != 10 * B + 1)) begin
                    errors++; $display("FAIL b2b_tsre j=%0d got %b want %b", j, tsre, j != 10 * B + 1);
                end
            end
            if (j == 10 * B + 1 || j == 23 * B - 1) begin
                checks++;
                if (tbre !== 1'b1) begin
                    errors++; $display("FAIL b2b_tbre_empty j=%0d got %b want 1", j, tbre);
                end
            end
            case (j)
                1: begin drv = b; drv_en = 1'b1; wrn = 1'b0; end
                3: begin wrn = 1'b1; drv_en = 1'b0; end
                5: begin drv = 8'h77; drv_en = 1'b1; wrn = 1'b0; end
                7: begin wrn = 1'b1; drv_en = 1'b0; end
                default: ;
            endcase
        end
    endtask

    task automatic test_receive();
        logic [7:0] d;
        int         cyc;
        for (int n = 0; n < 3; n++) begin
            d = (n == 0) ? 8'h3C : 8'($urandom);
            send_rx(d, 1'b1);
            cyc = 0;
            while (!dataReady && cyc < 2 * B) begin
                @(negedge clk); cyc++;
            end
            checks++;
            if (dataReady !== 1'b1) begin
                errors++; $display("FAIL rx_ready d=%h got %b want 1", d, dataReady);
            end
            rdn = 1'b0;
            @(negedge clk);
            checks++;
            if (bus !== d) begin
                errors++; $display("FAIL rx_read got %h want %h", bus, d);
            end
            rdn = 1'b1;
            @(negedge clk);
            checks++;
            if (dataReady !== 1'b0) begin
                errors++; $display("FAIL rx_clear d=%h got %b want 0", d, dataReady);
            end
        end
    endtask

    task automatic test_errors();
        logic [7:0] a, b, c, e;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); e = 8'($urandom);
        // Short glitch is not a start bit.
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (12 * B) @(negedge clk);
        checks++;
        if (dataReady !== 1'b0) begin
            errors++; $display("FAIL glitch got %b want 0", dataReady);
        end
        // Framing error discards the byte.
        send_rx(a, 1'b0);
        repeat (2 * B) @(negedge clk);
        checks++;
        if (dataReady !== 1'b0) begin
            errors++; $display("FAIL framing got %b want 0", dataReady);
        end
        // Overrun: second byte replaces the first.
        send_rx(a, 1'b1);
        send_rx(b, 1'b1);
        repeat (2) @(negedge clk);
        rdn = 1'b0;
        @(negedge clk);
        checks++;
        if ({dataReady, bus} !== {1'b1, b}) begin
            errors++; $display("FAIL overrun got %b_%h want 1_%h", dataReady, bus, b);
        end
        // Completion coincident with the rdn rising edge keeps dataReady set.
        fork
            send_rx(c, 1'b1);
            begin repeat (79) @(negedge clk); rdn = 1'b1; end
        join
        @(negedge clk);
        checks++;
        if (dataReady !== 1'b1) begin
            errors++; $display("FAIL same_cycle got %b want 1", dataReady);
        end
        // RBR stays put while rdn is held low across a completion.
        rdn = 1'b0;
        send_rx(e, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (bus !== c) begin
            errors++; $display("FAIL read_stable got %h want %h", bus, c);
        end
        rdn = 1'b1;
        @(negedge clk);
        rdn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus !== e) begin
            errors++; $display("FAIL deferred_rbr got %h want %h", bus, e);
        end
        rdn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        int cyc;
        rdn = 1'b0;
        @(negedge clk);
        rdn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dataReady !== 1'b0) begin
            errors++; $display("FAIL lb_clear got %b want 0", dataReady);
        end
        rxd = 1'b0;
        cpu_write(8'h5A);
        cyc = 0;
        while (!dataReady && cyc < 12 * B) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (dataReady !== 1'b1) begin
            errors++; $display("FAIL lb_ready got %b want 1", dataReady);
        end
        rdn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus !== 8'h5A) begin
            errors++; $display("FAIL lb_read got %h want 5a", bus);
        end
        rdn = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
`ifdef CPLD_UART_LOOPBACK_EN
        test_loopback();
`else
        test_receive();
        test_errors();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
